// File: rtl/sample_accumulator_16bit_if.sv
// Sample/result handshake bundle for sample_accumulator_16bit.
// The master side is the sample source and result consumer; the slave side is the accumulator.
interface sample_accumulator_16bit_if;
  logic        start;
  logic        clear;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        overflow_flag;
  logic        busy;

  modport master (
    output start, clear, sample_in, sample_valid, result_ready,
    input  sample_ready, result, result_valid, overflow_flag, busy
  );

  modport slave (
    input  start, clear, sample_in, sample_valid, result_ready,
    output sample_ready, result, result_valid, overflow_flag, busy
  );
endinterface

// File: rtl/sample_accumulator_16bit.sv
// Burst accumulator around a 16-bit ripple adder. It sums SAMPLE_COUNT samples and offers the total on a result handshake.
// Optional macro ACCUM_SATURATE_EN clamps the accumulator to 16'hFFFF once a carry has occurred in the burst.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        overflow
);
  logic [16:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = carry_in;
    for (int i = 0; i < 16; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    overflow = carry[16];
  end
endmodule

module sample_accumulator_16bit #(
  parameter int SAMPLE_COUNT = 8,
  parameter int COUNT_BITS   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  sample_accumulator_16bit_if.slave   bus,
  output logic [1:0]                  dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // sample_ready is high exactly while in ACCUM; result_valid holds until result_ready is seen.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           acc_q, acc_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic [15:0]           result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic                  sample_ready_q, sample_ready_d;
  logic                  overflow_q, overflow_d;
  logic                  busy_q, busy_d;

  logic [15:0] add_sum;
  logic        add_ovf;
  logic [15:0] acc_next;
  logic        last_sample;

  adder_16bit u_adder (
    .a        (acc_q),
    .b        (bus.sample_in),
    .carry_in (1'b0),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

`ifdef ACCUM_SATURATE_EN
  // Once the burst has carried, every further accept pins the total at full scale.
  assign acc_next = (add_ovf || overflow_q) ? 16'hFFFF : add_sum;
`else
  assign acc_next = add_sum;
`endif

  assign last_sample = (count_q == COUNT_BITS'(SAMPLE_COUNT - 1));

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    count_d        = count_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    sample_ready_d = sample_ready_q;
    overflow_d     = overflow_q;
    busy_d         = busy_q;
    if (bus.clear) begin
      // Abort keeps acc, result and overflow_flag; only control state is dropped.
      state_d        = IDLE;
      result_valid_d = 1'b0;
      sample_ready_d = 1'b0;
      busy_d         = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            acc_d          = '0;
            count_d        = '0;
            overflow_d     = 1'b0;
            sample_ready_d = 1'b1;
            busy_d         = 1'b1;
            state_d        = ACCUM;
          end
        end
        ACCUM: begin
          if (bus.sample_valid && sample_ready_q) begin
            acc_d      = acc_next;
            overflow_d = overflow_q | add_ovf;
            count_d    = count_q + COUNT_BITS'(1);
            if (last_sample) begin
              result_d       = acc_next;
              result_valid_d = 1'b1;
              sample_ready_d = 1'b0;
              state_d        = DONE;
            end
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            result_valid_d = 1'b0;
            busy_d         = 1'b0;
            state_d        = IDLE;
          end
        end
        default: begin
          state_d        = IDLE;
          result_valid_d = 1'b0;
          sample_ready_d = 1'b0;
          busy_d         = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      count_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      sample_ready_q <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      count_q        <= count_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      sample_ready_q <= sample_ready_d;
      overflow_q     <= overflow_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.result        = result_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.sample_ready  = sample_ready_q;
  assign bus.overflow_flag = overflow_q;
  assign bus.busy          = busy_q;
  assign dbg_state         = state_q;

  // Unknown control or data while out of reset would make the burst total meaningless.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown({bus.start, bus.clear, bus.sample_valid, bus.result_ready}))
        else $error("sample_accumulator_16bit: X/Z on control input");
      assert (!$isunknown(bus.sample_in))
        else $error("sample_accumulator_16bit: X/Z on sample_in");
    end
  end
endmodule

// File: tb/tb_sample_accumulator_16bit.sv
// Randomised bench for sample_accumulator_16bit; accepted samples are scored against an integer-sum model.
module tb_sample_accumulator_16bit;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] stim_q[$];

  sample_accumulator_16bit_if bus ();

  sample_accumulator_16bit #(.SAMPLE_COUNT(N), .COUNT_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the wrapped sum is the integer total mod 2^16, and a carry happened iff the total exceeds 16 bits.
  function automatic int unsigned model_total();
    int unsigned t = 0;
    foreach (exp_q[i]) t += 32'(exp_q[i]);
    return t;
  endfunction

  function automatic logic [15:0] model_result(input int unsigned t);
`ifdef ACCUM_SATURATE_EN
    if (t > 32'd65535) return 16'hFFFF;
`endif
    return 16'(t);
  endfunction

  task automatic do_start();
    exp_q.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.sample_ready !== 1'b1 || bus.overflow_flag !== 1'b0) begin
      errors++;
      $display("FAIL start_enter busy=%b ready=%b ovf=%b want 1 1 0", bus.busy, bus.sample_ready, bus.overflow_flag);
    end
  endtask

  // mode 0: valid always high, 1: toggling, 2: random
  task automatic feed(input int n, input int mode);
    int got = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit v;
    while (got < n && cyc < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = 1'($urandom_range(0, 1));
      endcase
      tog = !tog;
      bus.sample_valid = v;
      bus.sample_in    = v ? stim_q[0] : 16'($urandom);
      if (v && bus.sample_ready === 1'b1) begin
        exp_q.push_back(stim_q.pop_front());
        got++;
      end
      tick();
      cyc++;
    end
    bus.sample_valid = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL feed_timeout accepted=%0d want %0d", got, n);
    end
  endtask

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(16'($urandom));
  endtask

  task automatic finish_burst(input int stall);
    int unsigned t = model_total();
    logic [15:0] er = model_result(t);
    logic        eo = (t > 32'd65535);
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_valid got %b want 1", bus.result_valid);
    end
    checks++;
    if (bus.result !== er) begin
      errors++;
      $display("FAIL result got %h want %h", bus.result, er);
    end
    checks++;
    if (bus.overflow_flag !== eo) begin
      errors++;
      $display("FAIL overflow_flag got %b want %b", bus.overflow_flag, eo);
    end
    checks++;
    if (bus.sample_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL done_ctrl ready=%b busy=%b want 0 1", bus.sample_ready, bus.busy);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      checks++;
      if (bus.result_valid !== 1'b1 || bus.result !== er || bus.overflow_flag !== eo) begin
        errors++;
        $display("FAIL stall_hold rv=%b res=%h ovf=%b want 1 %h %b", bus.result_valid, bus.result, bus.overflow_flag, er, eo);
      end
    end
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    checks++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL return_idle rv=%b busy=%b ready=%b want 0 0 0", bus.result_valid, bus.busy, bus.sample_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.result !== 16'h0 || bus.result_valid !== 1'b0 || bus.sample_ready !== 1'b0 ||
        bus.overflow_flag !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values res=%h rv=%b ready=%b ovf=%b busy=%b want 0000 0 0 0 0",
               bus.result, bus.result_valid, bus.sample_ready, bus.overflow_flag, bus.busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    stim_q.delete();
    for (int i = 1; i <= N; i++) stim_q.push_back(16'(i));
    do_start();
    feed(N, 0);
    checks++;
    if (bus.result !== 16'h0024) begin
      errors++;
      $display("FAIL basic_sum got %h want 0024", bus.result);
    end
    finish_burst(0);
  endtask

  task automatic test_overflow_wrap();
    stim_q.delete();
    stim_q.push_back(16'hFFFF);
    stim_q.push_back(16'h0002);
    for (int i = 0; i < N - 2; i++) stim_q.push_back(16'h0000);
    do_start();
    feed(N, 0);
    finish_burst(1);
  endtask

  task automatic test_stalls();
    stim_q.delete();
    for (int i = 1; i <= N; i++) stim_q.push_back(16'(i));
    do_start();
    feed(N, 1);
    finish_burst(5);
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      fill_random(N);
      if (b % 2 == 1) stim_q[0] = 16'hF000 | 16'($urandom);
      do_start();
      feed(N, 2);
      finish_burst($urandom_range(0, 4));
    end
  endtask

  task automatic test_clear();
    stim_q.delete();
    stim_q.push_back(16'hFFFF);
    stim_q.push_back(16'hFFFF);
    stim_q.push_back(16'h0001);
    do_start();
    feed(3, 0);
    bus.clear        = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = 16'h1234;
    tick();
    bus.clear        = 1'b0;
    bus.sample_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle busy=%b rv=%b ready=%b want 0 0 0", bus.busy, bus.result_valid, bus.sample_ready);
    end
    checks++;
    if (bus.overflow_flag !== 1'b1) begin
      errors++;
      $display("FAIL clear_holds_ovf got %b want 1", bus.overflow_flag);
    end
    tick();
    stim_q.delete();
    for (int i = 0; i < N; i++) stim_q.push_back(16'h0001);
    do_start();
    feed(N, 2);
    checks++;
    if (bus.result !== 16'(N)) begin
      errors++;
      $display("FAIL clear_restart got %h want %h", bus.result, 16'(N));
    end
    finish_burst(0);
  endtask

  task automatic test_reset_mid();
    fill_random(N + 5);
    do_start();
    feed(5, 0);
    rst = 1'b1;
    tick();
    checks++;
    if (bus.result !== 16'h0 || bus.result_valid !== 1'b0 || bus.sample_ready !== 1'b0 ||
        bus.overflow_flag !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid res=%h rv=%b ready=%b ovf=%b busy=%b want 0000 0 0 0 0",
               bus.result, bus.result_valid, bus.sample_ready, bus.overflow_flag, bus.busy);
    end
    rst = 1'b0;
    tick();
    fill_random(N);
    do_start();
    feed(N, 2);
    finish_burst(2);
  endtask

  task automatic test_start_filter();
    int unsigned t;
    fill_random(N);
    do_start();
    feed(3, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.sample_ready !== 1'b1 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_in_accum busy=%b ready=%b rv=%b want 1 1 0", bus.busy, bus.sample_ready, bus.result_valid);
    end
    feed(N - 3, 0);
    t = model_total();
    bus.start = 1'b1;
    tick();
    checks++;
    if (bus.result_valid !== 1'b1 || bus.busy !== 1'b1 || bus.result !== model_result(t)) begin
      errors++;
      $display("FAIL start_in_done rv=%b busy=%b res=%h want 1 1 %h", bus.result_valid, bus.busy, bus.result, model_result(t));
    end
    bus.result_ready = 1'b1;
    tick();
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.sample_ready !== 1'b0 || bus.result_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_with_ready busy=%b ready=%b rv=%b want 0 0 0", bus.busy, bus.sample_ready, bus.result_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.result_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      fill_random(N);
      do_start();
      feed(N, 2);
      checks++;
      if (bus.result_valid !== 1'b1 || bus.result !== model_result(model_total())) begin
        errors++;
        $display("FAIL b2b_result rv=%b res=%h want 1 %h", bus.result_valid, bus.result, model_result(model_total()));
      end
      tick();
      checks++;
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_release rv=%b busy=%b want 0 0", bus.result_valid, bus.busy);
      end
    end
    bus.result_ready = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.clear        = 1'b0;
    bus.sample_in    = 16'h0;
    bus.sample_valid = 1'b0;
    bus.result_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow_wrap();
    test_stalls();
    test_random();
    test_clear();
    test_reset_mid();
    test_start_filter();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
